// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and funct3 encodings for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering, legality check and load extension
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    always_comb begin
        be         = 4'b0000;
        lane_wdata = req_wdata;
        illegal    = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << req_addr_lo;
                lane_wdata = {4{req_wdata[7:0]}};
                illegal    = req_we && (req_funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                be         = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata[15:0]}};
                illegal    = req_addr_lo[0] || (req_we && (req_funct3 == F3_HU));
            end
            F3_W: begin
                be      = 4'b1111;
                illegal = (req_addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        // Loads always fetch the whole word; lane selection happens on return.
        if (!req_we)
            be = 4'b1111;
    end

    always_comb begin
        ld_shifted = ld_word >> {ld_addr_lo, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_BU:   ld_data = {24'h000000, ld_shifted[7:0]};
            F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_HU:   ld_data = {16'h0000, ld_shifted[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_bus_adapter.sv
// rtl/lsu_bus_adapter.sv - load/store unit bridging the core data port to a handshaked bus
module lsu_bus_adapter
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int BUS_AW         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_funct3,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_stall,
    output logic [31:0]       core_rdata,
    output logic              core_misaligned,
    output logic              core_access_fault,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic              bus_err,
    input  logic [31:0]       bus_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t  state, state_next;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]  req_funct3;
    logic [1:0]  req_addr_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ld_data;
    logic        illegal;
    logic        complete;
    logic        timeout;

    lsu_lane_align u_lane (
        .req_we      (core_we),
        .req_funct3  (core_funct3),
        .req_addr_lo (core_addr[1:0]),
        .req_wdata   (core_wdata),
        .be          (lane_be),
        .lane_wdata  (lane_wdata),
        .illegal     (illegal),
        .ld_funct3   (req_funct3),
        .ld_addr_lo  (req_addr_lo),
        .ld_word     (bus_rdata),
        .ld_data     (ld_data)
    );

    // Completion is only meaningful once the request has been accepted.
    assign complete = (state == WAIT) && bus_rvalid;
    assign timeout  = ((state == REQ) || (state == WAIT)) &&
                      (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (core_req) state_next = illegal ? DONE : REQ;
            REQ: begin
                if (timeout)
                    state_next = DONE;
                else if (bus_ready)
                    state_next = WAIT;
            end
            WAIT: if (complete || timeout) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_valid  = (state == REQ);
        core_stall = core_req && (state != DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt           <= '0;
            bus_we            <= 1'b0;
            bus_addr          <= '0;
            bus_be            <= 4'b0000;
            bus_wdata         <= 32'h0;
            req_funct3        <= 3'b000;
            req_addr_lo       <= 2'b00;
            core_rdata        <= 32'h0;
            core_misaligned   <= 1'b0;
            core_access_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (core_req) begin
                        if (illegal) begin
                            core_misaligned <= 1'b1;
                        end else begin
                            bus_we      <= core_we;
                            bus_addr    <= {core_addr[BUS_AW-1:2], 2'b00};
                            bus_be      <= lane_be;
                            bus_wdata   <= lane_wdata;
                            req_funct3  <= core_funct3;
                            req_addr_lo <= core_addr[1:0];
                        end
                    end
                end
                REQ, WAIT: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (complete) begin
                        if (bus_err) begin
                            core_access_fault <= 1'b1;
                            core_rdata        <= 32'h0;
                        end else if (!bus_we) begin
                            core_rdata <= ld_data;
                        end
                    end else if (timeout) begin
                        core_access_fault <= 1'b1;
                        core_rdata        <= 32'h0;
                    end
                end
                DONE: begin
                    core_misaligned   <= 1'b0;
                    core_access_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb/tb_lsu_bus_adapter.sv - directed self-checking bench for lsu_bus_adapter
module tb_lsu_bus_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        core_misaligned;
    logic        core_access_fault;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic        bus_err;
    logic [31:0] bus_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    int          stall_cycles;
    int          valid_cycles;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_we;
    logic [31:0] done_rdata;
    logic        done_mis;
    logic        done_fault;
    logic        done_seen;

    lsu_bus_adapter dut (
        .clk               (clk),
        .reset             (reset),
        .core_req          (core_req),
        .core_we           (core_we),
        .core_funct3       (core_funct3),
        .core_addr         (core_addr),
        .core_wdata        (core_wdata),
        .core_stall        (core_stall),
        .core_rdata        (core_rdata),
        .core_misaligned   (core_misaligned),
        .core_access_fault (core_access_fault),
        .bus_valid         (bus_valid),
        .bus_ready         (bus_ready),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_be            (bus_be),
        .bus_wdata         (bus_wdata),
        .bus_rvalid        (bus_rvalid),
        .bus_err           (bus_err),
        .bus_rdata         (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rdy_wait < 0 means the bus never accepts.
    task automatic run_xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int rdy_wait, input logic [31:0] rd,
                            input logic err, input int rsp_wait);
        bit acc;
        int wcnt;
        int cyc;
        acc = 0; wcnt = 0; cyc = 0;
        stall_cycles = 0; valid_cycles = 0;
        cap_addr = 'x; cap_be = 'x; cap_wdata = 'x; cap_we = 1'bx;
        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wd;
        bus_rdata = rd; bus_err = err;
        #1;
        while (core_stall === 1'b1 && cyc < 100) begin
            if (acc) wcnt++;
            bus_rvalid = acc && (wcnt > rsp_wait);
            if (bus_valid === 1'b1) begin
                valid_cycles++;
                cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata; cap_we = bus_we;
            end
            bus_ready = (bus_valid === 1'b1) && (rdy_wait >= 0) && (valid_cycles > rdy_wait);
            if (bus_ready) acc = 1;
            stall_cycles++;
            tick();
            cyc++;
        end
        done_seen  = (core_stall === 1'b0);
        done_rdata = core_rdata;
        done_mis   = core_misaligned;
        done_fault = core_access_fault;
        core_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_funct3 = 3'b000;
        core_addr = 32'h0; core_wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        bus_err = 1'b0; bus_rdata = 32'h0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_bus_valid", {31'b0, bus_valid}, 32'h0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_faults", {30'b0, core_misaligned, core_access_fault}, 32'h0);
        tick();

        // LW 0x100, zero-wait bus
        run_xfer(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0);
        chk("lw_done", {31'b0, done_seen}, 32'h1);
        chk("lw_addr", cap_addr, 32'h0000_0100);
        chk("lw_be", {28'b0, cap_be}, 32'hF);
        chk("lw_we", {31'b0, cap_we}, 32'h0);
        chk("lw_stall", stall_cycles, 3);
        chk("lw_valid", valid_cycles, 1);
        chk("lw_rdata", done_rdata, 32'hDEAD_BEEF);
        chk("lw_faults", {30'b0, done_mis, done_fault}, 32'h0);

        // LB / LBU at 0x203
        run_xfer(1'b0, 3'b000, 32'h0000_0203, 32'h0, 0, 32'h80FF_1234, 1'b0, 0);
        chk("lb_addr", cap_addr, 32'h0000_0200);
        chk("lb_be", {28'b0, cap_be}, 32'hF);
        chk("lb_rdata", done_rdata, 32'hFFFF_FF80);
        run_xfer(1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, 32'h80FF_1234, 1'b0, 0);
        chk("lbu_rdata", done_rdata, 32'h0000_0080);
        chk("lbu_after_idle", core_rdata, 32'h0000_0080);

        // SH 0x302 with bus_ready delayed 3 cycles
        run_xfer(1'b1, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 3, 32'h1111_1111, 1'b0, 0);
        chk("sh_valid", valid_cycles, 4);
        chk("sh_be", {28'b0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'b0, cap_we}, 32'h1);
        chk("sh_addr", cap_addr, 32'h0000_0300);
        chk("sh_stall", stall_cycles, 6);
        chk("sh_faults", {30'b0, done_mis, done_fault}, 32'h0);
        chk("sh_rdata_held", done_rdata, 32'h0000_0080);

        // SB 0x001 with one-cycle response delay
        run_xfer(1'b1, 3'b000, 32'h0000_0001, 32'h1234_565A, 0, 32'h0, 1'b0, 1);
        chk("sb_be", {28'b0, cap_be}, 32'h2);
        chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        chk("sb_stall", stall_cycles, 4);

        // Illegal accesses: no bus activity, one stall cycle
        run_xfer(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h0, 1'b0, 0);
        chk("mis_lw_valid", valid_cycles, 0);
        chk("mis_lw_flag", {31'b0, done_mis}, 32'h1);
        chk("mis_lw_stall", stall_cycles, 1);
        chk("mis_cleared", {31'b0, core_misaligned}, 32'h0);
        run_xfer(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0, 1'b0, 0);
        chk("bad_f3_flag", {31'b0, done_mis}, 32'h1);
        run_xfer(1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h0, 1'b0, 0);
        chk("sbu_flag", {31'b0, done_mis}, 32'h1);
        chk("sbu_valid", valid_cycles, 0);
        run_xfer(1'b0, 3'b001, 32'h0000_0003, 32'h0, 0, 32'h0, 1'b0, 0);
        chk("mis_lh_flag", {31'b0, done_mis}, 32'h1);

        // Bus error on LH
        run_xfer(1'b0, 3'b001, 32'h0000_0002, 32'h0, 0, 32'h80FF_1234, 1'b1, 0);
        chk("err_fault", {31'b0, done_fault}, 32'h1);
        chk("err_rdata", done_rdata, 32'h0);

        // LH / LHU upper half
        run_xfer(1'b0, 3'b001, 32'h0000_0002, 32'h0, 0, 32'h80FF_1234, 1'b0, 0);
        chk("lh_rdata", done_rdata, 32'hFFFF_80FF);

        // Timeout: bus never accepts
        run_xfer(1'b0, 3'b010, 32'h0000_0400, 32'h0, -1, 32'h0, 1'b0, 0);
        chk("tmo_done", {31'b0, done_seen}, 32'h1);
        chk("tmo_valid", valid_cycles, 16);
        chk("tmo_stall", stall_cycles, 17);
        chk("tmo_fault", {31'b0, done_fault}, 32'h1);
        chk("tmo_rdata", done_rdata, 32'h0);
        chk("tmo_bus_valid", {31'b0, bus_valid}, 32'h0);
        chk("tmo_cleared", {31'b0, core_access_fault}, 32'h0);

        run_xfer(1'b0, 3'b101, 32'h0000_0002, 32'h0, 0, 32'h80FF_1234, 1'b0, 0);
        chk("lhu_rdata", done_rdata, 32'h0000_80FF);

        // Reset while in WAIT, then a stray response
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h0000_0500;
        tick();
        chk("rw_req", {31'b0, bus_valid}, 32'h1);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        chk("rw_wait", {31'b0, bus_valid}, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        chk("rr_bus_valid", {31'b0, bus_valid}, 32'h0);
        chk("rr_bus_addr", bus_addr, 32'h0);
        chk("rr_bus_be", {28'b0, bus_be}, 32'h0);
        chk("rr_bus_wdata", bus_wdata, 32'h0);
        chk("rr_core_rdata", core_rdata, 32'h0);
        chk("rr_stall", {31'b0, core_stall}, 32'h1);
        core_req = 1'b0;
        tick();
        bus_rvalid = 1'b0;
        chk("rr_ignored_rdata", core_rdata, 32'h0);
        chk("rr_no_fault", {30'b0, core_misaligned, core_access_fault}, 32'h0);
        chk("rr_bus_valid2", {31'b0, bus_valid}, 32'h0);
        core_req = 1'b1;
        #1;
        chk("rr_idle_stall", {31'b0, core_stall}, 32'h1);
        core_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
Load/store unit between the core datapath's ALU/register-file outputs and a handshaked data bus. It is directly downstream of the datapath's data-memory port.
- Converts RISC-V byte, half and word accesses into word-aligned bus transfers with byte enables.
- Extracts and sign/zero-extends load data.
- Stalls the core until the transfer completes.
- Detects misalignment, invalid size codes and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in REQ+WAIT before the transfer aborts with core_access_fault; must be >=2
BUS_AW, 32, bus address width; bus_addr carries addr[BUS_AW-1:2] with bits [1:0] forced to 0

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
core_req  in  1  load or store present this cycle; held stable by core while core_stall=1
core_we  in  1  1=store, 0=load
core_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
core_addr  in  32  byte address (ALU result)
core_wdata  in  32  store data (rs2)
core_stall  out  1  freeze PC/regfile write this cycle
core_rdata  out  32  extended load data, valid in DONE
core_misaligned  out  1  valid in DONE: misaligned or invalid funct3, no bus transfer issued
core_access_fault  out  1  valid in DONE: bus error or timeout
bus_valid  out  1  request valid
bus_ready  in  1  request accepted when bus_valid&bus_ready
bus_we  out  1  write
bus_addr  out  BUS_AW  word address, [1:0]=0
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_rvalid  in  1  response (reads and writes)
bus_err  in  1  qualifies bus_rvalid
bus_rdata  in  32  read word

Behaviour:
- Clock/reset: clk, reset synchronous active-high. On reset: state=IDLE, bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, core_rdata=0, both fault flags 0, timeout counter 0.
- Reset mid-transfer aborts silently. A late bus_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- core_stall = core_req & (state != DONE). This is combinational, so it is already high in the IDLE cycle a request appears.
- IDLE, core_req=1, legal access: register bus_addr/bus_be/bus_wdata/bus_we, go to REQ.
- IDLE, core_req=1, illegal access: set core_misaligned, go to DONE. No bus activity.
  - Illegal means: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 in {100,101}.
- REQ: bus_valid=1. Request fields are stable until accepted. On bus_ready, go to WAIT and drop bus_valid next cycle.
- WAIT: on bus_rvalid, go to DONE.
  - If bus_err=1: core_access_fault=1, core_rdata=0.
  - Else, for loads: core_rdata = extended lane. Stores ignore bus_rdata.
- Timeout counter: clears on IDLE->REQ and counts each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES with no completion: bus_valid=0, core_access_fault=1, go to DONE.
- DONE: lasts exactly one cycle. core_stall=0 so the core retires the instruction, then state goes to IDLE and fault flags clear.
  - core_rdata holds its value until the next capture.
  - A new core_req in the following IDLE cycle starts a new transfer; there are no back-to-back bubbles beyond DONE.
- Minimum latency with zero-wait bus (bus_ready in REQ, bus_rvalid the next cycle): 3 stall cycles, release in cycle 4.
- Store lanes:
  - B: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - W: be = 1111.
- Loads: bus_be=1111. Lane is selected by addr[1:0]. B/H are sign-extended, BU/HU zero-extended.
- Simultaneous events:
  - bus_rvalid in REQ (before acceptance) is ignored.
  - Completion and timeout in the same cycle: completion wins.

Decomposition:
- Package lsu_pkg holds:
  - the state enum lsu_state_t {IDLE, REQ, WAIT, DONE};
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
- One combinational sub-module, lsu_lane_align, builds bus_be/bus_wdata, computes the illegal-access flag, and extracts/extends load data. The FSM, timeout counter and registers stay in the top module.

Test Plan:
- LW addr=0x100, bus_ready and bus_rvalid each with 0 wait, rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, stall high 3 cycles, DONE core_rdata=0xDEADBEEF.
- LB addr=0x203 then LBU same addr, rdata=0x80FF1234 -> be=1111; core_rdata=0xFFFFFF80 then 0x00000080.
- SH addr=0x302 wdata=0x0000ABCD, bus_ready delayed 3 cycles -> bus_valid held 4 cycles with be=1100, wdata=0xABCDABCD; DONE after rvalid, no faults.
- LW addr=0x101 -> no bus_valid ever; next cycle DONE with core_misaligned=1, stall released after 1 cycle.
- LW with bus_ready never asserted, TIMEOUT_CYCLES=16 -> bus_valid drops, core_access_fault=1, core_rdata=0, stall released.
- Reset asserted while in WAIT, then bus_rvalid=1 next cycle -> state IDLE, rvalid ignored, all outputs at reset values, no DONE pulse.
